// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the core IO register bus between several masters
module io_bus_arbiter #(
    parameter int NUM_REQUESTERS = 2,
    parameter int READ_LATENCY   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQUESTERS-1:0]    req,
    input  logic [NUM_REQUESTERS-1:0]    req_write,
    input  logic [32*NUM_REQUESTERS-1:0] req_address,
    input  logic [32*NUM_REQUESTERS-1:0] req_write_data,
    output logic [NUM_REQUESTERS-1:0]    req_ack,
    output logic [NUM_REQUESTERS-1:0]    req_read_valid,
    output logic [31:0]                  req_read_data,
    output logic                         io_write_en,
    output logic                         io_read_en,
    output logic [31:0]                  io_address,
    output logic [31:0]                  io_write_data,
    input  logic [31:0]                  io_read_data,
    output logic                         busy
);
    localparam int GW = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [GW-1:0] last_grant, grant, sel, cand;
    logic          found;
    logic [1:0]    cnt;

    // first requesting master searching upward from the one after last_grant
    always_comb begin
        sel   = last_grant;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQUESTERS; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_REQUESTERS);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_grant     <= GW'(NUM_REQUESTERS - 1);
            grant          <= '0;
            cnt            <= '0;
            req_ack        <= '0;
            req_read_valid <= '0;
            req_read_data  <= '0;
            io_write_en    <= 1'b0;
            io_read_en     <= 1'b0;
            io_address     <= '0;
            io_write_data  <= '0;
            busy           <= 1'b0;
        end else begin
            req_ack        <= '0;
            req_read_valid <= '0;
            io_write_en    <= 1'b0;
            io_read_en     <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    grant         <= sel;
                    last_grant    <= sel;
                    io_address    <= req_address[32*sel +: 32];
                    io_write_data <= req_write_data[32*sel +: 32];
                    io_write_en   <= req_write[sel];
                    io_read_en    <= !req_write[sel];
                    req_ack[sel]  <= req_write[sel];
                    busy          <= 1'b1;
                    state         <= ISSUE;
                end
                ISSUE: if (io_write_en) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    cnt   <= 2'(READ_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: if (cnt == 2'd0) begin
                    req_read_data         <= io_read_data;
                    req_ack[grant]        <= 1'b1;
                    req_read_valid[grant] <= 1'b1;
                    state                 <= DONE;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed scoreboard bench for io_bus_arbiter (4 masters, read latency 2)
module tb_io_bus_arbiter;
    localparam int N  = 4;
    localparam int RL = 2;

    typedef struct {int m; bit wr; logic [31:0] addr; logic [31:0] data; logic [31:0] rdata;} iss_t;
    typedef struct {int m; logic [31:0] data; int due;} rd_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req, req_write, req_ack, req_read_valid, ack_seen, auto_drop;
    logic [32*N-1:0] req_address, req_write_data;
    logic [31:0]     req_read_data, io_address, io_write_data, io_read_data, slv_data;
    logic            io_write_en, io_read_en, busy;
    int              cyc = 0, n_asrt = 0, n_fail = 0, busy_cnt = 0, wen_cnt = 0, slv_cnt = 0;
    int              req_cyc, w;
    int              last_ack[N];
    int              ack_hist[$];
    iss_t            exp_iss[$];
    rd_t             exp_rd[$];
    iss_t            e;
    rd_t             r;

    io_bus_arbiter #(.NUM_REQUESTERS(N), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_write(req_write),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ack(req_ack), .req_read_valid(req_read_valid), .req_read_data(req_read_data),
        .io_write_en(io_write_en), .io_read_en(io_read_en), .io_address(io_address),
        .io_write_data(io_write_data), .io_read_data(io_read_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        n_asrt++;
        assert (cond === 1'b1) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=1", tag, cond);
        end
    endtask

    function automatic logic [31:0] slv(input logic [31:0] a);
        return (a == 32'h8) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000) + 32'h11;
    endfunction

    function automatic logic [31:0] onehot(input int m);
        return 32'(1) << m;
    endfunction

    // slave model plus scoreboard, all sampled mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_iss.delete();
            exp_rd.delete();
            ack_seen = '0;
            slv_cnt  = 0;
        end else begin
            if (slv_cnt != 0) begin
                slv_cnt--;
                io_read_data = (slv_cnt == 0) ? slv_data : 32'hBAD0BAD0;
            end else io_read_data = 32'hBAD0BAD0;
            if (io_read_en) begin
                slv_cnt  = RL;
                slv_data = slv(io_address);
            end
            if (io_write_en || io_read_en) begin
                chk("strobe_excl", 32'(io_write_en & io_read_en), 32'd0);
                chk_true("iss_expected", exp_iss.size() != 0);
                if (exp_iss.size() != 0) begin
                    e = exp_iss.pop_front();
                    chk("iss_wr", 32'(io_write_en), 32'(e.wr));
                    chk("iss_addr", io_address, e.addr);
                    chk("iss_busy", 32'(busy), 32'd1);
                    chk("iss_ack", 32'(req_ack), e.wr ? onehot(e.m) : 32'd0);
                    if (e.wr) chk("iss_wdata", io_write_data, e.data);
                    else exp_rd.push_back('{e.m, e.rdata, cyc + RL + 1});
                end
            end else if (req_ack != 0 || req_read_valid != 0) begin
                chk_true("rd_expected", exp_rd.size() != 0);
                if (exp_rd.size() != 0) begin
                    r = exp_rd.pop_front();
                    chk("rd_valid", 32'(req_read_valid), onehot(r.m));
                    chk("rd_ack", 32'(req_ack), onehot(r.m));
                    chk("rd_data", req_read_data, r.data);
                    chk("rd_cycle", cyc, r.due);
                end
            end
            if (exp_rd.size() != 0) chk_true("rd_late", cyc <= exp_rd[0].due);
            for (int i = 0; i < N; i++) if (req_ack[i]) last_ack[i] = cyc;
            if (req_ack != 0) ack_hist.push_back(cyc);
            ack_seen = req_ack;
            busy_cnt += int'(busy);
            wen_cnt  += int'(io_write_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (auto_drop[i] && ack_seen[i]) req[i] = 1'b0;
    endtask

    task automatic raise(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
        req_write[m] = wr;
        req_address[32*m +: 32] = a;
        req_write_data[32*m +: 32] = d;
        req[m] = 1'b1;
    endtask

    task automatic expect_iss(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d);
        exp_iss.push_back('{m, wr, a, d, slv(a)});
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100 && !(req == 0 && !busy && exp_iss.size() == 0 && exp_rd.size() == 0); k++) tick();
        chk_true("idle_timeout", k < 100);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, 32'(req_ack), 32'd0);
        chk({tag, "_valid"}, 32'(req_read_valid), 32'd0);
        chk({tag, "_rdata"}, req_read_data, 32'd0);
        chk({tag, "_wen"}, 32'(io_write_en), 32'd0);
        chk({tag, "_ren"}, 32'(io_read_en), 32'd0);
        chk({tag, "_addr"}, io_address, 32'd0);
        chk({tag, "_wdata"}, io_write_data, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; req_write = '0; req_address = '0; req_write_data = '0;
        auto_drop = '1; ack_seen = '0; io_read_data = '0;
        tick(); tick();
        check_zero("reset");
        #2 reset_n = 1'b1;
        tick();

        // single write from master 0
        busy_cnt = 0; wen_cnt = 0;
        expect_iss(0, 1'b1, 32'h4, 32'h1FF);
        raise(0, 1'b1, 32'h4, 32'h1FF);
        req_cyc = cyc;
        wait_idle();
        chk("w_busy_cycles", busy_cnt, 1);
        chk("w_strobe_cycles", wen_cnt, 1);
        chk("w_ack_latency", last_ack[0] - req_cyc, 1);

        // read from master 1 with latency 2
        expect_iss(1, 1'b0, 32'h8, 32'h0);
        raise(1, 1'b0, 32'h8, 32'h0);
        req_cyc = cyc;
        wait_idle();
        chk("r_valid_latency", last_ack[1] - req_cyc, RL + 2);
        tick(); tick(); tick();
        chk("r_data_held", req_read_data, 32'hDEADBEEF);

        // second read, different master and address
        expect_iss(3, 1'b0, 32'h44, 32'h0);
        raise(3, 1'b0, 32'h44, 32'h0);
        wait_idle();

        // masters 0 and 1 requesting continuously
        auto_drop[1:0] = 2'b00;
        ack_hist.delete();
        expect_iss(0, 1'b1, 32'h10, 32'hA0);
        expect_iss(1, 1'b1, 32'h14, 32'hA1);
        expect_iss(0, 1'b1, 32'h10, 32'hA0);
        expect_iss(1, 1'b1, 32'h14, 32'hA1);
        raise(0, 1'b1, 32'h10, 32'hA0);
        raise(1, 1'b1, 32'h14, 32'hA1);
        for (w = 0; w < 50 && ack_hist.size() < 4; w++) tick();
        chk_true("cont_timeout", w < 50);
        req[1:0] = 2'b00;
        auto_drop[1:0] = 2'b11;
        wait_idle();
        if (ack_hist.size() >= 4) begin
            chk("cont_gap01", ack_hist[1] - ack_hist[0], 2);
            chk("cont_period0", ack_hist[2] - ack_hist[0], 4);
            chk("cont_period1", ack_hist[3] - ack_hist[1], 4);
        end

        // round robin after master 2 was last granted
        expect_iss(2, 1'b1, 32'h50, 32'hB2);
        raise(2, 1'b1, 32'h50, 32'hB2);
        wait_idle();
        expect_iss(3, 1'b1, 32'h63, 32'hC3);
        expect_iss(1, 1'b1, 32'h61, 32'hC1);
        expect_iss(2, 1'b1, 32'h62, 32'hC2);
        raise(1, 1'b1, 32'h61, 32'hC1);
        raise(2, 1'b1, 32'h62, 32'hC2);
        raise(3, 1'b1, 32'h63, 32'hC3);
        wait_idle();

        // asynchronous reset in the middle of a read wait
        expect_iss(0, 1'b0, 32'h20, 32'h0);
        raise(0, 1'b0, 32'h20, 32'h0);
        for (w = 0; w < 20 && !io_read_en; w++) tick();
        chk_true("rd_issue_timeout", w < 20);
        tick();
        #2 reset_n = 1'b0;
        req = '0;
        #1 check_zero("async");
        tick(); tick();
        #2 reset_n = 1'b1;
        tick();
        expect_iss(0, 1'b1, 32'h70, 32'hD0);
        expect_iss(1, 1'b1, 32'h74, 32'hD1);
        raise(0, 1'b1, 32'h70, 32'hD0);
        raise(1, 1'b1, 32'h74, 32'hD1);
        wait_idle();

        // request held one cycle past ack repeats the transaction
        auto_drop[0] = 1'b0;
        expect_iss(0, 1'b1, 32'h30, 32'hAA);
        expect_iss(0, 1'b1, 32'h30, 32'hAA);
        raise(0, 1'b1, 32'h30, 32'hAA);
        for (w = 0; w < 20 && !ack_seen[0]; w++) tick();
        chk_true("hold_timeout", w < 20);
        tick();
        req[0] = 1'b0;
        auto_drop[0] = 1'b1;
        wait_idle();

        // correctly dropped request issues once
        expect_iss(2, 1'b1, 32'h34, 32'hBB);
        raise(2, 1'b1, 32'h34, 32'hBB);
        wait_idle();
        repeat (6) tick();
        chk("iss_queue_empty", exp_iss.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares the single core-side IO register bus (io_write_en / io_read_en / io_address / io_write_data / io_read_data) between NUM_REQUESTERS masters, e.g. the gpgpu IO port and a host debug/loader master.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences each access as a one-cycle strobe to the IO peripherals, plus a fixed read-return wait.
- Sits in the FPGA top level between the masters and the LED/hex/peripheral register decode.

Parameters:
NUM_REQUESTERS, 2, number of masters (2..8)
READ_LATENCY, 1, cycles from io_read_en to valid io_read_data (1..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active low
req  in  NUM_REQUESTERS  per-master request, held until ack
req_write  in  NUM_REQUESTERS  1 = write, 0 = read, per master
req_address  in  32*NUM_REQUESTERS  flattened addresses, master i at [32*i+31:32*i]
req_write_data  in  32*NUM_REQUESTERS  flattened write data
req_ack  out  NUM_REQUESTERS  one-cycle completion pulse, per master
req_read_valid  out  NUM_REQUESTERS  one-cycle read-data-valid pulse, per master
req_read_data  out  32  read data for the master currently pulsing req_read_valid
io_write_en  out  1  write strobe to peripherals
io_read_en  out  1  read strobe to peripherals
io_address  out  32  peripheral address
io_write_data  out  32  peripheral write data
io_read_data  in  32  peripheral read data, valid READ_LATENCY cycles after io_read_en
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low. Asserting reset_n low at any time, including mid-transaction, forces:
  - state IDLE
  - all outputs 0 (strobes, acks, valids, io_address, io_write_data, req_read_data, busy)
  - last_grant = NUM_REQUESTERS-1, so master 0 has highest priority after reset.
  - An in-flight transaction is abandoned; no ack is issued.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from last_grant+1, modulo NUM_REQUESTERS.
  - Register the grant index, req_write, address and write data; update last_grant; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive io_address and io_write_data from the registered values; assert io_write_en if write, else io_read_en. Never both.
  - Write: req_ack[grant] = 1 this cycle; go to IDLE.
  - Read: load the wait counter with READ_LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, capture io_read_data into req_read_data at the clock edge; go to DONE.
- DONE (one cycle): req_ack[grant] = 1 and req_read_valid[grant] = 1; go to IDLE.
- req_read_data holds its value until the next read capture.
- io_address and io_write_data hold the last issued values outside ISSUE; the strobes are 0 outside ISSUE.
- Timing:
  - Write: ack one cycle after the request is seen in IDLE; 2 cycles per write.
  - Read: valid READ_LATENCY+2 cycles after the request is seen; READ_LATENCY+3 cycles per read.
- Requester rule:
  - req, req_write, address and data stay stable from assertion through the ack cycle.
  - req must drop on the edge that samples ack high; if req is still high in the following IDLE cycle, it is a new request.
- Changes to req on non-granted masters during a transaction have no effect until IDLE.
- Simultaneous requests are served strictly round-robin. A continuously requesting master waits at most NUM_REQUESTERS-1 transactions.
- All outputs are registered or decoded from registered state; there is no combinational path from req to any output.

Test Plan:
- Reset, then only master 0 writes addr 0x4, data 0x1FF -> io_write_en high for exactly 1 cycle with io_address=0x4, io_write_data=0x1FF; req_ack[0] in the same cycle; busy high for 1 cycle.
- READ_LATENCY=2; master 1 reads addr 0x8; slave drives 0xDEADBEEF 2 cycles after io_read_en -> req_read_valid[1] and req_ack[1] at cycle 4 after the request; req_read_data=0xDEADBEEF, held afterwards.
- Masters 0 and 1 both request continuously (writes) -> grant order 0,1,0,1; each ack every 4 cycles; io_write_en never overlaps io_read_en.
- NUM_REQUESTERS=4, requests on masters 1, 2 and 3 after master 2 was last granted -> order 3,1,2.
- Assert reset_n low during WAIT of a read -> all outputs 0 immediately (asynchronous); no req_ack or req_read_valid; after release, master 0 wins a simultaneous 0/1 request.
- Master holds req high one cycle past ack -> a second identical transaction is issued (documented behaviour); req dropped correctly -> no duplicate.
